// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial test-sequence source (CLOCK / PRBS7 / PRBS15 / WORD)
// with bit-boundary rate/pattern switching and single-bit error injection.
module seq_pattern_tx #(
  parameter int                WORD_W = 16,
  parameter logic [WORD_W-1:0] WORD   = 16'hF0C3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] speedctr_i,
  input  logic [1:0] pattern_sel_i,
  input  logic       inject_err_i,
  output logic       ser_out_o,
  output logic       bit_strobe_o,
  output logic       frame_start_o,
  output logic       err_pending_o
);

  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

  typedef enum logic [1:0] {
    PAT_CLOCK  = 2'b00,
    PAT_PRBS7  = 2'b01,
    PAT_PRBS15 = 2'b10,
    PAT_WORD   = 2'b11
  } pat_e;

  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    speed_q, speed_d;
  pat_e          pat_q, pat_d;
  logic [6:0]    prbs7_q, prbs7_d;
  logic [14:0]   prbs15_q, prbs15_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          phase_q, phase_d;
  logic          ser_q, ser_d;
  logic          strobe_q, strobe_d;
  logic          frame_q, frame_d;
  logic          errp_q, errp_d;

  logic          tick;
  logic          chg;
  logic [6:0]    p7;
  logic [14:0]   p15;
  logic [IW-1:0] ix;
  logic          ph;
  logic          bit_v;
  logic          fs;

  assign tick = (cnt_q == speed_q);

  // State register; async reset returns every generator to its seed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      speed_q  <= '0;
      pat_q    <= PAT_CLOCK;
      prbs7_q  <= 7'h7F;
      prbs15_q <= 15'h7FFF;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      ser_q    <= 1'b0;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
      errp_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      speed_q  <= speed_d;
      pat_q    <= pat_d;
      prbs7_q  <= prbs7_d;
      prbs15_q <= prbs15_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      ser_q    <= ser_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
      errp_q   <= errp_d;
    end
  end

  // Bit timer, boundary load, generator advance and error flip.
  always_comb begin
    cnt_d    = cnt_q;
    speed_d  = speed_q;
    pat_d    = pat_q;
    prbs7_d  = prbs7_q;
    prbs15_d = prbs15_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    ser_d    = ser_q;
    strobe_d = 1'b0;
    frame_d  = 1'b0;
    errp_d   = errp_q | inject_err_i;
    chg      = 1'b0;
    p7       = prbs7_q;
    p15      = prbs15_q;
    ix       = idx_q;
    ph       = phase_q;
    bit_v    = 1'b0;
    fs       = 1'b0;
    if (!tick) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d   = '0;
      speed_d = speedctr_i;
      pat_d   = pat_e'(pattern_sel_i);
      chg     = (pattern_sel_i != pat_q);
      // A zero LFSR would lock up; treat it as a reseed.
      p7  = (chg || prbs7_q == '0) ? 7'h7F : prbs7_q;
      p15 = (chg || prbs15_q == '0) ? 15'h7FFF : prbs15_q;
      ix  = chg ? '0 : idx_q;
      ph  = chg ? 1'b0 : phase_q;
      unique case (pat_e'(pattern_sel_i))
        PAT_CLOCK: begin
          bit_v   = ~ph;
          fs      = ~ph;
          phase_d = ~ph;
        end
        PAT_PRBS7: begin
          bit_v   = p7[6];
          fs      = (p7 == 7'h7F);
          prbs7_d = {p7[5:0], p7[6] ^ p7[5]};
        end
        PAT_PRBS15: begin
          bit_v    = p15[14];
          fs       = (p15 == 15'h7FFF);
          prbs15_d = {p15[13:0], p15[14] ^ p15[13]};
        end
        PAT_WORD: begin
          bit_v = WORD[IDX_LAST - ix];
          fs    = (ix == '0);
          idx_d = (ix == IDX_LAST) ? '0 : ix + 1'b1;
        end
      endcase
      ser_d    = bit_v ^ errp_q;
      strobe_d = 1'b1;
      frame_d  = fs | chg;
      errp_d   = inject_err_i;
    end
  end

  assign ser_out_o     = ser_q;
  assign bit_strobe_o  = strobe_q;
  assign frame_start_o = frame_q;
  assign err_pending_o = errp_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: random + directed stimulus against a sequence-level
// reference model (precomputed pattern tables indexed by period position).
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic [3:0] speedctr;
  logic [1:0] pattern_sel;
  logic       inject;
  logic       ser_out;
  logic       bit_strobe;
  logic       frame_start;
  logic       err_pending;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] WORD = 16'hF0C3;

  bit s7  [127];
  bit s15 [32767];

  int m_cnt, m_spd, m_pat, m_pos;
  bit m_errp;
  bit e_ser, e_stb, e_frm;

  seq_pattern_tx #(.WORD_W(16), .WORD(WORD)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .speedctr_i    (speedctr),
    .pattern_sel_i (pattern_sel),
    .inject_err_i  (inject),
    .ser_out_o     (ser_out),
    .bit_strobe_o  (bit_strobe),
    .frame_start_o (frame_start),
    .err_pending_o (err_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int period(input int p);
    case (p)
      0: return 2;
      1: return 127;
      2: return 32767;
      default: return 16;
    endcase
  endfunction

  function automatic bit seq_bit(input int p, input int pos);
    case (p)
      0: return (pos == 0);
      1: return s7[pos];
      2: return s15[pos];
      default: return WORD[15-pos];
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_spd = 0; m_pat = 0; m_pos = 0; m_errp = 0;
    e_ser = 0; e_stb = 0; e_frm = 0;
  endtask

  task automatic model_step();
    if (m_cnt == m_spd) begin
      m_spd = int'(speedctr);
      if (int'(pattern_sel) != m_pat) begin
        m_pat = int'(pattern_sel);
        m_pos = 0;
      end
      e_ser  = seq_bit(m_pat, m_pos) ^ m_errp;
      e_frm  = (m_pos == 0);
      e_stb  = 1;
      m_pos  = (m_pos + 1) % period(m_pat);
      m_errp = inject;
      m_cnt  = 0;
    end else begin
      m_cnt++;
      e_stb  = 0;
      e_frm  = 0;
      m_errp = m_errp | inject;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ser_out", ser_out, e_ser);
    chk("bit_strobe", bit_strobe, e_stb);
    chk("frame_start", frame_start, e_frm);
    chk("err_pending", err_pending, m_errp);
  endtask

  // n cycles; inj_rate/spd_rate 0 disables random inject / speed change
  task automatic run(input int sel, input int spd, input int n,
                     input int inj_rate, input int spd_rate);
    pattern_sel = 2'(sel);
    speedctr    = 4'(spd);
    for (int i = 0; i < n; i++) begin
      inject = (inj_rate > 0) && ($urandom % inj_rate == 0);
      if (spd_rate > 0 && $urandom % spd_rate == 0)
        speedctr = 4'($urandom_range(0, 15));
      cycle();
    end
    inject = 0;
  endtask

  initial begin
    for (int n = 0; n < 127; n++)
      s7[n] = (n < 7) ? 1'b1 : s7[n-7] ^ s7[n-6];
    for (int n = 0; n < 32767; n++)
      s15[n] = (n < 15) ? 1'b1 : s15[n-15] ^ s15[n-14];

    rst = 1; speedctr = 0; pattern_sel = 0; inject = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ser", ser_out, 0);
    chk("rst_stb", bit_strobe, 0);
    chk("rst_frm", frame_start, 0);
    chk("rst_err", err_pending, 0);
    rst = 0;

    run(0, 0, 40, 0, 0);
    run(1, 3, 3 * 127 * 4 + 8, 0, 0);
    run(1, 3, 200, 0, 6);
    run(3, 1, 100, 0, 0);
    run(2, 0, 32800, 0, 0);
    run(0, 2, 60, 0, 0);

    // two pulses inside one long bit, then clean bits
    pattern_sel = 1; speedctr = 9;
    for (int i = 0; i < 60; i++) begin
      inject = (i == 22 || i == 25);
      cycle();
    end
    inject = 0;

    // asynchronous reset mid-bit with PRBS15
    run(2, 5, 53, 0, 0);
    #1 rst = 1;
    #1;
    chk("arst_ser", ser_out, 0);
    chk("arst_stb", bit_strobe, 0);
    chk("arst_frm", frame_start, 0);
    chk("arst_err", err_pending, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    run(2, 5, 300, 0, 0);

    for (int s = 0; s < 20; s++)
      run($urandom_range(0, 3), $urandom_range(0, 15), 300, 15, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
